// File: rtl/mul_issue_pkg.sv
// rtl/mul_issue_pkg.sv - shared types and constants for the multiplier issue block
package mul_issue_pkg;

  localparam int TAG_W   = 4;
  localparam int OPA_W   = 4;
  localparam int OPB_W   = 4;
  localparam int PROD_W  = 8;
  localparam int ENTRY_W = TAG_W + OPA_W + OPB_W;

  localparam logic [PROD_W-1:0] TIMEOUT_PROD = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [OPA_W-1:0] a;
    logic [OPB_W-1:0] b;
  } entry_t;

endpackage

// File: rtl/mul_opfifo.sv
// rtl/mul_opfifo.sv - operand FIFO with registered occupancy and full/empty flags
module mul_opfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/mul_issue.sv
// rtl/mul_issue.sv - queues operand pairs and issues them to an external shift-add multiplier
module mul_issue
  import mul_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPA_W-1:0]  op_a,
  input  logic [OPB_W-1:0]  op_b,
  output logic              mul_st,
  output logic [OPA_W-1:0]  mul_mndo,
  output logic [OPB_W-1:0]  mul_mdor,
  input  logic [PROD_W-1:0] mul_prod,
  input  logic              mul_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_prod,
  output logic [TAG_W-1:0]  res_tag,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT     = CW'(TIMEOUT);
  localparam logic [CW-1:0] FIRST_LIVE = CW'(2);

  state_e              state_q;
  logic [TAG_W-1:0]    tag_q, tag_d, cur_tag_q;
  logic [CW-1:0]       wait_cnt_q;
  logic                mul_st_q, res_valid_q, err_q;
  logic [OPA_W-1:0]    mndo_q;
  logic [OPB_W-1:0]    mdor_q;
  logic [PROD_W-1:0]   res_prod_q;
  logic [TAG_W-1:0]    res_tag_q;
  logic                fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0]  head_raw;
  entry_t              push_entry, head;

  assign push       = op_valid && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && (!res_valid_q || res_ready);
  assign push_entry = '{tag: tag_q, a: op_a, b: op_b};
  assign head       = entry_t'(head_raw);

  always_comb begin
    tag_d = tag_q;
    if (push) tag_d = tag_q + 1'b1;
  end

  mul_opfifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      cur_tag_q   <= '0;
      wait_cnt_q  <= '0;
      mul_st_q    <= 1'b0;
      mndo_q      <= '0;
      mdor_q      <= '0;
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
      res_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      tag_q <= tag_d;
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            mndo_q    <= head.a;
            mdor_q    <= head.b;
            cur_tag_q <= head.tag;
            mul_st_q  <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          mul_st_q   <= 1'b0;
          wait_cnt_q <= CW'(1);
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // wait_cnt_q counts cycles since START; a done in the first WAIT cycle is stale
          if (mul_done && wait_cnt_q >= FIRST_LIVE) begin
            res_valid_q <= 1'b1;
            res_prod_q  <= mul_prod;
            res_tag_q   <= cur_tag_q;
            state_q     <= ST_HOLD;
          end else if (wait_cnt_q == TO_CNT) begin
            err_q       <= 1'b1;
            res_valid_q <= 1'b1;
            res_prod_q  <= TIMEOUT_PROD;
            res_tag_q   <= cur_tag_q;
            state_q     <= ST_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!mul_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready  = !fifo_full;
  assign mul_st    = mul_st_q;
  assign mul_mndo  = mndo_q;
  assign mul_mdor  = mdor_q;
  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign res_tag   = res_tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_issue.sv
// tb/tb_mul_issue.sv - scoreboard bench for mul_issue with a behavioural multiplier model
module tb_mul_issue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] prod;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0, op_ready;
  logic [3:0] op_a = '0, op_b = '0;
  logic       mul_st;
  logic [3:0] mul_mndo, mul_mdor;
  logic [7:0] mul_prod = '0;
  logic       mul_done = 1'b0;
  logic       res_valid, res_ready = 1'b1;
  logic [7:0] res_prod;
  logic [3:0] res_tag;
  logic       err;

  int   vectors = 0, miscompares = 0;
  exp_t sb_q[$];
  int   tag_model = 0, results = 0, st_count = 0, cyc = 0;
  int   last_acc_cyc = 0, last_acc_res = 0;

  int         lat = 9, hold_len = 2;
  bit         stale = 0, never = 0, lat_rand = 0;
  int         cnt = 0, hold_c = 0, stale_c = 0;
  logic [3:0] ma = '0, mb = '0;
  bit         prev_st = 0;

  always #5 clk = ~clk;

  mul_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mul_st    (mul_st),
    .mul_mndo  (mul_mndo),
    .mul_mdor  (mul_mdor),
    .mul_prod  (mul_prod),
    .mul_done  (mul_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .res_tag   (res_tag),
    .err       (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // result monitor: every cycle a result is presented it must match the scoreboard head
  initial forever begin
    @(negedge clk);
    if (rst && res_valid) begin
      if (sb_q.size() == 0) begin
        chk("result_with_empty_scoreboard", sb_q.size(), 1);
      end else begin
        chk("res_prod", res_prod, sb_q[0].prod);
        chk("res_tag", res_tag, sb_q[0].tag);
        if (res_ready) begin
          void'(sb_q.pop_front());
          results++;
        end
      end
    end
  end

  // multiplier model: done after lat cycles, held for hold_len cycles
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cnt = 0; hold_c = 0; stale_c = 0; mul_done = 1'b0; prev_st = 0;
    end else begin
      if (mul_st) begin
        st_count++;
        chk("st_while_done", mul_done, 0);
        chk("st_single_cycle", int'(prev_st), 0);
      end
      if (stale_c > 0) begin
        stale_c--;
        if (stale_c == 0) mul_done = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("operands_stable", {mul_mndo, mul_mdor}, {ma, mb});
          mul_done = 1'b1;
          mul_prod = {4'd0, ma} * {4'd0, mb};
          hold_c   = hold_len;
        end
      end else if (hold_c > 0) begin
        hold_c--;
        if (hold_c == 0) mul_done = 1'b0;
      end
      if (mul_st && !never) begin
        ma  = mul_mndo;
        mb  = mul_mdor;
        cnt = lat_rand ? int'($urandom_range(3, 12)) : lat;
        if (stale) begin
          mul_done = 1'b1;
          mul_prod = 8'hA5;
          stale_c  = 2;
        end
      end
      prev_st = mul_st;
    end
  end

  // called in the posedge+1 phase; returns in the posedge+1 phase
  task automatic push_op(input logic [3:0] a, input logic [3:0] b);
    bit   ok = 0;
    exp_t e;
    op_a = a; op_b = b; op_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (op_ready) begin ok = 1; break; end
    end
    chk("push_accept", int'(ok), 1);
    if (ok) begin
      e.tag  = 4'(tag_model);
      e.prod = never ? 8'hFF : ({4'd0, a} * {4'd0, b});
      sb_q.push_back(e);
      tag_model    = (tag_model + 1) % 16;
      last_acc_cyc = cyc;
      last_acc_res = results;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_st();
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mul_st) begin seen = 1; break; end
    end
    chk("wait_mul_st", int'(seen), 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin ok = 1; break; end
    end
    chk("drain_scoreboard", int'(ok), 1);
    sb_q.delete();
    repeat (hold_len + 12) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_op_ready"}, op_ready, 1);
    chk({tagname, "_mul_st"}, mul_st, 0);
    chk({tagname, "_mul_mndo"}, mul_mndo, 0);
    chk({tagname, "_mul_mdor"}, mul_mdor, 0);
    chk({tagname, "_res_valid"}, res_valid, 0);
    chk({tagname, "_res_prod"}, res_prod, 0);
    chk({tagname, "_res_tag"}, res_tag, 0);
    chk({tagname, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int t0, st_base, acc_c[8], acc_r[8];
    bit seen;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // single operation
    push_op(4'd3, 4'd5);
    drain();

    // fill the FIFO while the multiplier is busy
    for (int k = 0; k < DEPTH + 2; k++) begin
      push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      acc_c[k] = last_acc_cyc;
      acc_r[k] = last_acc_res;
    end
    chk("fill_consecutive_accepts", acc_c[DEPTH] - acc_c[0], DEPTH);
    chk("fill_stalled_when_full", int'(acc_c[DEPTH+1] - acc_c[DEPTH] > 1), 1);
    chk("fill_accept_after_result", int'(acc_r[DEPTH+1] >= 1), 1);
    drain();

    // result backpressure
    res_ready = 1'b0;
    st_base = st_count;
    push_op(4'd7, 4'd9);
    push_op(4'd12, 4'd11);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1; break; end
    end
    chk("bp_first_result", int'(seen), 1);
    repeat (20) @(negedge clk);
    chk("bp_no_second_start", st_count - st_base, 1);
    chk("bp_result_held", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
    chk("bp_second_started", st_count - st_base, 2);

    // stale done at WAIT entry, long done in HOLD
    stale = 1; hold_len = 10;
    push_op(4'd13, 4'd6);
    push_op(4'd2, 4'd14);
    drain();
    stale = 0; hold_len = 2;

    // timeout
    never = 1;
    push_op(4'd9, 4'd9);
    wait_st();
    t0 = cyc;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err) begin seen = 1; break; end
    end
    chk("timeout_err_seen", int'(seen), 1);
    chk("timeout_err_latency", cyc - t0, TIMEOUT + 1);
    drain();
    never = 0;
    push_op(4'd4, 4'd4);
    drain();
    chk("err_sticky", err, 1);

    // randomized traffic with random downstream stalls and multiplier latency
    lat_rand = 1;
    fork
      begin
        for (int k = 0; k < 12; k++)
          push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      begin
        repeat (300) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    drain();
    lat_rand = 0;

    // reset while waiting on the multiplier
    push_op(4'd10, 4'd10);
    wait_st();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb_q.delete();
    tag_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push_op(4'd15, 4'd15);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
